// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT result writer
// and the peak-bin detector that scans the same RAM.
package fft_pkg;

    localparam int N_POINTS = 1024;
    localparam int ADDR_W   = 10;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 14;
    localparam int DATA_W   = 2 * OUT_W;
    localparam int DROP_W   = 8;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE,
        WAIT_DET
    } wr_state_t;

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp from IN_W to OUT_W bits.
// No rounding; values outside the OUT_W range pin to the extremes.
module sat_clamp #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 14
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // Bits that must all match the sign for the value to fit.
    logic [IN_W-OUT_W:0] top;

    assign top = din[IN_W-1:OUT_W-1];

    always_comb begin
        if (top == '0 || top == '1) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fft_result_writer.sv
// Captures one bit-reversed FFT frame into the channel-1 RAM, then
// signals the detector and holds off new frames until it finishes.
module fft_result_writer
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic signed [IN_W-1:0]   in_real,
    input  logic signed [IN_W-1:0]   in_imag,
    output logic                     in_ready,
    input  logic                     detectdone,
    output logic                     ram_wren,
    output logic [ADDR_W-1:0]        ram_wraddr,
    output logic [DATA_W-1:0]        ram_data,
    output logic                     fftdone,
    output logic                     frame_err,
    output logic [DROP_W-1:0]        drop_cnt
);

    wr_state_t             state;
    wr_state_t             state_nx;
    logic [ADDR_W-1:0]     idx;
    logic [ADDR_W-1:0]     idx_nx;
    logic [ADDR_W-1:0]     waddr;
    logic                  accept;
    logic                  err_set;
    logic                  drop_inc;
    logic                  sop_hit;
    logic                  is_last;
    logic signed [OUT_W-1:0] re_sat;
    logic signed [OUT_W-1:0] im_sat;

    assign in_ready = 1'b1;
    assign sop_hit  = in_valid & in_sop;
    assign is_last  = (idx == LAST_IDX);

    sat_clamp #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_re (
        .din  (in_real),
        .dout (re_sat)
    );

    sat_clamp #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_im (
        .din  (in_imag),
        .dout (im_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sop_hit) state_nx = WRITE;
            end
            WRITE: begin
                if (in_valid && !in_sop) begin
                    if (in_eop && is_last) begin
                        state_nx = DONE;
                    end else if (in_eop || is_last) begin
                        state_nx = IDLE;
                    end
                end
            end
            DONE: begin
                state_nx = WAIT_DET;
            end
            WAIT_DET: begin
                if (detectdone) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // idx always holds the index the next in-frame sample will take.
    always_comb begin
        accept   = 1'b0;
        waddr    = '0;
        idx_nx   = idx;
        err_set  = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (sop_hit) begin
                    accept = 1'b1;
                    idx_nx = ADDR_W'(1);
                end
            end
            WRITE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sop) begin
                        idx_nx  = ADDR_W'(1);
                        err_set = 1'b1;
                    end else begin
                        waddr   = idx;
                        idx_nx  = idx + 1'b1;
                        err_set = in_eop ^ is_last;
                    end
                end
            end
            DONE: begin
            end
            WAIT_DET: begin
                drop_inc = sop_hit;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= '0;
        end else begin
            idx      <= idx_nx;
            ram_wren <= accept;
            if (accept) begin
                ram_wraddr <= waddr;
                ram_data   <= {re_sat, im_sat};
            end
        end
    end

    // Registering DONE places fftdone one cycle after the last write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fftdone   <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            fftdone   <= (state == DONE);
            frame_err <= frame_err | err_set;
            if (drop_inc && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_result_writer.sv
// Bench for fft_result_writer: frame-level reference model, saturation
// table, and hand sequences for drops, malformed frames and async reset.
module tb_fft_result_writer;
    import fft_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_sop = 1'b0;
    logic               in_eop = 1'b0;
    logic signed [15:0] in_real = '0;
    logic signed [15:0] in_imag = '0;
    logic               in_ready;
    logic               detectdone = 1'b0;
    logic               ram_wren;
    logic [9:0]         ram_wraddr;
    logic [27:0]        ram_data;
    logic               fftdone;
    logic               frame_err;
    logic [7:0]         drop_cnt;

    fft_result_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .in_ready   (in_ready),
        .detectdone (detectdone),
        .ram_wren   (ram_wren),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .fftdone    (fftdone),
        .frame_err  (frame_err),
        .drop_cnt   (drop_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    typedef struct {
        int          addr;
        logic [27:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [13:0] exp_re;
        logic [13:0] exp_im;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    // Reference model: frame-level view of what should reach the RAM.
    wr_t  exp_q [$];
    bit   m_cap = 0;
    bit   m_busy = 0;
    bit   m_err = 0;
    int   m_pos = 0;
    int   m_drops = 0;
    int   m_done_exp = 0;

    logic [27:0] got_mem [N_POINTS];
    int   last_wr = -10;
    int   fft_cnt = 0;
    wr_t  mon_e;

    function automatic logic [13:0] sat(input int v);
        int t;
        t = v;
        if (t > 8191) t = 8191;
        if (t < -8192) t = -8192;
        return 14'(t);
    endfunction

    function automatic logic [27:0] pack(input logic signed [15:0] re,
                                         input logic signed [15:0] im);
        return {sat(int'(re)), sat(int'(im))};
    endfunction

    task automatic model_step(input bit v, input bit s, input bit e,
                              input logic signed [15:0] re,
                              input logic signed [15:0] im, input bit dd);
        wr_t w;
        if (v) begin
            if (m_busy) begin
                if (s && m_drops < 255) m_drops++;
            end else if (s) begin
                if (m_cap) m_err = 1;
                m_cap = 1;
                w.addr = 0;
                w.data = pack(re, im);
                exp_q.push_back(w);
                m_pos = 1;
            end else if (m_cap) begin
                w.addr = m_pos;
                w.data = pack(re, im);
                exp_q.push_back(w);
                if (e && m_pos == N_POINTS - 1) begin
                    m_cap = 0;
                    m_busy = 1;
                    m_done_exp++;
                end else if (e || m_pos == N_POINTS - 1) begin
                    m_err = 1;
                    m_cap = 0;
                end
                m_pos++;
            end
        end
        if (dd && m_busy) m_busy = 0;
    endtask

    always @(negedge clk) begin
        if (ram_wren) begin
            got_mem[ram_wraddr] = ram_data;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                if (errors <= 30)
                    $display("FAIL unexpected_wren: got addr %0d want no write",
                             ram_wraddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_wraddr), mon_e.addr);
                chk("wr_data", 32'(ram_data), 32'(mon_e.data));
            end
        end
        if (fftdone) begin
            fft_cnt++;
            chk("fftdone_expected", 32'(m_done_exp > 0), 1);
            chk("fftdone_timing", cyc, last_wr + 1);
            if (m_done_exp > 0) m_done_exp--;
        end
    end

    task automatic drive(input bit v, input bit s, input bit e,
                         input logic signed [15:0] re,
                         input logic signed [15:0] im, input bit dd);
        in_valid   = v;
        in_sop     = s;
        in_eop     = e;
        in_real    = re;
        in_imag    = im;
        detectdone = dd;
        model_step(v, s, e, re, im, dd);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        detectdone = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0);
    endtask

    // mode 0: ramp real=i imag=-i; 1: random; 2: table then random.
    task automatic send_frame(input int n, input int mode, input int gap_max,
                              input bit with_eop);
        logic signed [15:0] re;
        logic signed [15:0] im;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                re = 16'(i);
                im = 16'(-i);
            end else if (mode == 2 && i < NV) begin
                re = tbl[i].re;
                im = tbl[i].im;
            end else begin
                re = 16'($urandom);
                im = 16'($urandom);
            end
            drive(1, i == 0, with_eop && i == n - 1, re, im, 0);
            if (gap_max > 0) begin
                for (int g = 0; g < int'($urandom_range(gap_max, 0)); g++)
                    drive(0, $urandom_range(1, 0) == 1, 0, '0, '0, 0);
            end
        end
    endtask

    task automatic pulse_detect();
        idle(3);
        drive(0, 0, 0, '0, '0, 1);
        idle(2);
    endtask

    task automatic settle(input string name);
        idle(4);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        chk({name, "_pending_fftdone"}, m_done_exp, 0);
        chk({name, "_frame_err"}, 32'(frame_err), 32'(m_err));
        chk({name, "_drop_cnt"}, 32'(drop_cnt), m_drops);
        chk({name, "_in_ready"}, 32'(in_ready), 1);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        exp_q.delete();
        m_cap = 0;
        m_busy = 0;
        m_err = 0;
        m_drops = 0;
        m_done_exp = 0;
        #1;
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_fftdone", 32'(fftdone), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int f0;

    initial begin
        tbl[0] = '{16'h7FFF, 16'h8000, 14'h1FFF, 14'h2000};
        tbl[1] = '{16'h1FFF, 16'hE000, 14'h1FFF, 14'h2000};
        tbl[2] = '{16'h2000, 16'hDFFF, 14'h1FFF, 14'h2000};
        tbl[3] = '{16'h0000, 16'h0000, 14'h0000, 14'h0000};
        tbl[4] = '{16'h0001, 16'hFFFF, 14'h0001, 14'h3FFF};
        tbl[5] = '{16'hFFFF, 16'h0001, 14'h3FFF, 14'h0001};
        tbl[6] = '{16'h8000, 16'h7FFF, 14'h2000, 14'h1FFF};
        tbl[7] = '{16'h1000, 16'hF000, 14'h1000, 14'h3000};
        tbl[8] = '{16'h4000, 16'hC000, 14'h1FFF, 14'h2000};

        #5;
        apply_reset();

        // Clean ramp frame.
        f0 = fft_cnt;
        send_frame(N_POINTS, 0, 0, 1);
        settle("t1");
        chk("t1_fft_cnt", fft_cnt - f0, 1);
        chk("t1_last_word", 32'(got_mem[N_POINTS-1]), 32'({14'd1023, 14'h3C01}));
        pulse_detect();

        // Saturation table embedded at the head of a frame.
        send_frame(N_POINTS, 2, 1, 1);
        settle("t2");
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("t2_tbl%0d_re", i), 32'(got_mem[i][27:14]),
                32'(tbl[i].exp_re));
            chk($sformatf("t2_tbl%0d_im", i), 32'(got_mem[i][13:0]),
                32'(tbl[i].exp_im));
        end
        pulse_detect();

        // Frame arriving before detectdone is dropped.
        f0 = fft_cnt;
        send_frame(N_POINTS, 0, 0, 1);
        idle(5);
        send_frame(N_POINTS, 1, 0, 1);
        settle("t3a");
        chk("t3_drop_cnt", 32'(drop_cnt), 1);
        chk("t3_fft_cnt_a", fft_cnt - f0, 1);
        pulse_detect();
        send_frame(N_POINTS, 1, 2, 1);
        settle("t3b");
        chk("t3_fft_cnt_b", fft_cnt - f0, 2);
        pulse_detect();

        // Mid-frame sop restarts capture at address 0.
        f0 = fft_cnt;
        send_frame(300, 1, 0, 0);
        send_frame(N_POINTS, 0, 0, 1);
        settle("t5");
        chk("t5_frame_err", 32'(frame_err), 1);
        chk("t5_fft_cnt", fft_cnt - f0, 1);
        pulse_detect();

        apply_reset();

        // Short frame: eop at index 500.
        f0 = fft_cnt;
        send_frame(501, 1, 0, 1);
        settle("t4a");
        chk("t4_frame_err", 32'(frame_err), 1);
        chk("t4_no_fftdone", fft_cnt - f0, 0);
        send_frame(N_POINTS, 1, 1, 1);
        settle("t4b");
        chk("t4_fft_cnt", fft_cnt - f0, 1);
        pulse_detect();

        // Async reset mid-frame.
        f0 = fft_cnt;
        send_frame(700, 0, 0, 0);
        chk("t6_wren_before", 32'(ram_wren), 1);
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_cap = 0;
        m_busy = 0;
        m_err = 0;
        m_drops = 0;
        #1;
        chk("t6_wren_async", 32'(ram_wren), 0);
        chk("t6_fftdone_async", 32'(fftdone), 0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_no_fftdone", fft_cnt - f0, 0);
        send_frame(N_POINTS, 0, 0, 1);
        settle("t6");
        chk("t6_fft_cnt", fft_cnt - f0, 1);
        pulse_detect();

        // Random frames with gaps and stray non-sop samples.
        for (int k = 0; k < 2; k++) begin
            f0 = fft_cnt;
            for (int j = 0; j < 3; j++)
                drive(1, 0, $urandom_range(1, 0) == 1, 16'($urandom),
                      16'($urandom), 0);
            send_frame(N_POINTS, 1, 2, 1);
            settle($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d_fft_cnt", k), fft_cnt - f0, 1);
            pulse_detect();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
